uart_cmd_ctrl: RTL

Terminal command sequencer between the UART byte engine and the fabric C2F port inside uart_tile.
- Parses the host byte stream: 'W' (0x57) + 4 address bytes + 4 data bytes, or 'R' (0x52) + 4 address bytes. All fields are MSB byte first.
- Issues one C2F request per command.
- For reads, waits for the RD_RSP response and streams the 4 data bytes back to the UART TX side. For writes, sends an ack byte.

---
 rtl/lotr_pkg.sv | 26 ++
 rtl/uart_cmd_txser.sv | 52 +++++
 rtl/uart_cmd_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/lotr_pkg.sv
// Shared fabric/UART definitions for the uart_tile command path.
//   t_opcode          : C2F request/response opcode
//   UART_CMD_WR/RD    : host command bytes ('W' / 'R')
//   t_uart_cmd_state  : command sequencer states
package lotr_pkg;

    typedef enum logic [1:0] {
        OP_WR     = 2'd0,
        OP_RD     = 2'd1,
        OP_WR_RSP = 2'd2,
        OP_RD_RSP = 2'd3
    } t_opcode;

    localparam logic [7:0] UART_CMD_WR = 8'h57;
    localparam logic [7:0] UART_CMD_RD = 8'h52;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        REQ,
        WAIT_RSP,
        TX
    } t_uart_cmd_state;

endpackage

// File: rtl/uart_cmd_txser.sv
// Byte serialiser for the UART TX side of the command sequencer.
// A load captures up to four bytes (MSB byte sent first) and a byte count;
// bytes are then offered one at a time with a valid/ready handshake.
//   clk, rst         : clock, synchronous active-high reset
//   load             : capture load_data / load_count this cycle
//   load_data        : bytes to send, [31:24] first
//   load_count       : number of bytes to send (1..4)
//   tx_valid/tx_data : current byte offered
//   tx_ready         : consumer accepts the current byte
//   last_accept      : final byte accepted this cycle
module uart_cmd_txser (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic [2:0]  load_count,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        last_accept
);

    logic [31:0] shift_q, shift_d;
    logic [2:0]  count_q, count_d;

    assign tx_valid    = (count_q != 3'd0);
    assign tx_data     = shift_q[31:24];
    assign last_accept = tx_valid & tx_ready & (count_q == 3'd1);

    always_comb begin
        shift_d = shift_q;
        count_d = count_q;
        if (load) begin
            shift_d = load_data;
            count_d = load_count;
        end else if (tx_valid && tx_ready) begin
            shift_d = {shift_q[23:0], 8'h00};
            count_d = count_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            count_q <= '0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Terminal command sequencer between the UART byte engine and the fabric
// C2F port. Parses 'W' + addr[4] + data[4] or 'R' + addr[4] (MSB first),
// issues one C2F request per command, then returns an ack byte (write),
// the four read-data bytes (read) or an error byte (read timeout).
//   QClk, RstQnnnH          : clock, synchronous active-high reset
//   RxByte*                 : received byte strobe/data
//   TxByte*                 : byte offered to UART TX with ready handshake
//   C2F_Req*Q500H           : fabric request (held until accepted)
//   C2F_Rsp*Q502H           : fabric response
//   C2F_RspStall            : fabric not accepting requests this cycle
//   Busy                    : command in progress
//   CmdErr                  : one-cycle pulse on bad opcode, RX overrun, timeout
module uart_cmd_ctrl
    import lotr_pkg::*;
#(
    parameter logic [1:0]  THREAD_ID      = 2'd0,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter logic [7:0]  ACK_BYTE       = 8'h4B,
    parameter logic [7:0]  ERR_BYTE       = 8'h45
) (
    input  logic        QClk,
    input  logic        RstQnnnH,
    input  logic        RxByteValid,
    input  logic [7:0]  RxByteData,
    output logic        TxByteValid,
    output logic [7:0]  TxByteData,
    input  logic        TxByteReady,
    output logic        C2F_ReqValidQ500H,
    output t_opcode     C2F_ReqOpcodeQ500H,
    output logic [1:0]  C2F_ReqThreadIDQ500H,
    output logic [31:0] C2F_ReqAddressQ500H,
    output logic [31:0] C2F_ReqDataQ500H,
    input  logic        C2F_RspValidQ502H,
    input  t_opcode     C2F_RspOpcodeQ502H,
    input  logic [1:0]  C2F_RspThreadIDQ502H,
    input  logic [31:0] C2F_RspDataQ502H,
    input  logic        C2F_RspStall,
    output logic        Busy,
    output logic        CmdErr
);

    localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    t_uart_cmd_state     state_q, state_d;
    t_opcode             op_q, op_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                req_valid_q, req_valid_d;
    logic                cmd_err_q, cmd_err_d;

    logic                accept;
    logic                rsp_match;
    logic                tx_load;
    logic [31:0]         tx_load_data;
    logic [2:0]          tx_load_count;
    logic                tx_last;

    assign accept    = req_valid_q & ~C2F_RspStall;
    assign rsp_match = C2F_RspValidQ502H
                     && (C2F_RspOpcodeQ502H == OP_RD_RSP)
                     && (C2F_RspThreadIDQ502H == THREAD_ID);

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        data_d        = data_q;
        timer_d       = timer_q;
        req_valid_d   = req_valid_q;
        cmd_err_d     = 1'b0;
        tx_load       = 1'b0;
        tx_load_data  = '0;
        tx_load_count = '0;

        case (state_q)
            IDLE: begin
                if (RxByteValid) begin
                    if (RxByteData == UART_CMD_WR) begin
                        op_d    = OP_WR;
                        cnt_d   = '0;
                        state_d = ADDR;
                    end else if (RxByteData == UART_CMD_RD) begin
                        op_d    = OP_RD;
                        cnt_d   = '0;
                        state_d = ADDR;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (RxByteValid) begin
                    addr_d = {addr_q[23:0], RxByteData};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (op_q == OP_WR) begin
                            state_d = DATA;
                        end else begin
                            state_d     = REQ;
                            req_valid_d = 1'b1;
                        end
                    end
                end
            end
            DATA: begin
                if (RxByteValid) begin
                    data_d = {data_q[23:0], RxByteData};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d     = REQ;
                        req_valid_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (accept) begin
                    req_valid_d = 1'b0;
                    if (op_q == OP_WR) begin
                        tx_load       = 1'b1;
                        tx_load_data  = {ACK_BYTE, 24'h000000};
                        tx_load_count = 3'd1;
                        state_d       = TX;
                    end else begin
                        timer_d = '0;
                        state_d = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                // A matching response on the final timer cycle takes priority.
                if (rsp_match) begin
                    tx_load       = 1'b1;
                    tx_load_data  = C2F_RspDataQ502H;
                    tx_load_count = 3'd4;
                    state_d       = TX;
                end else if (timer_q == TIMER_LAST) begin
                    cmd_err_d     = 1'b1;
                    tx_load       = 1'b1;
                    tx_load_data  = {ERR_BYTE, 24'h000000};
                    tx_load_count = 3'd1;
                    state_d       = TX;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            TX: begin
                if (tx_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Bytes arriving while a command is being executed are dropped.
        if (RxByteValid && ((state_q == REQ) || (state_q == WAIT_RSP) || (state_q == TX))) begin
            cmd_err_d = 1'b1;
        end
    end

    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            state_q     <= IDLE;
            op_q        <= OP_RD;
            cnt_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            timer_q     <= '0;
            req_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            timer_q     <= timer_d;
            req_valid_q <= req_valid_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    uart_cmd_txser u_txser (
        .clk         (QClk),
        .rst         (RstQnnnH),
        .load        (tx_load),
        .load_data   (tx_load_data),
        .load_count  (tx_load_count),
        .tx_ready    (TxByteReady),
        .tx_valid    (TxByteValid),
        .tx_data     (TxByteData),
        .last_accept (tx_last)
    );

    assign C2F_ReqValidQ500H    = req_valid_q;
    assign C2F_ReqOpcodeQ500H   = op_q;
    assign C2F_ReqThreadIDQ500H = THREAD_ID;
    assign C2F_ReqAddressQ500H  = addr_q;
    // Write data register keeps its last value; reads present zero.
    assign C2F_ReqDataQ500H     = (op_q == OP_WR) ? data_q : 32'h0;
    assign Busy                 = (state_q != IDLE);
    assign CmdErr               = cmd_err_q;

endmodule
